// File: rtl/quadenc_multi_if.sv
// Bundle of encoder pins, controls and readout for quadenc_multi.
// The master side drives pins/controls, the slave side is the decoder.
interface quadenc_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       quad_a;
  logic [NUM_CH-1:0]       quad_b;
  logic [NUM_CH-1:0]       clear;
  logic                    snap;
  logic [NUM_CH-1:0]       err_clr;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH*CNT_W-1:0] snap_count;
  logic [NUM_CH-1:0]       dir;
  logic [NUM_CH-1:0]       err;
  logic                    snap_valid;

  modport master (
    output quad_a, quad_b, clear, snap, err_clr,
    input  count, snap_count, dir, err, snap_valid
  );

  modport slave (
    input  quad_a, quad_b, clear, snap, err_clr,
    output count, snap_count, dir, err, snap_valid
  );
endinterface

// File: rtl/quadenc_multi.sv
// Multi-channel x4 quadrature decoder with glitch filter,
// sticky illegal-transition flags and coherent snapshot.
module quadenc_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input logic           clk,
  input logic           rst,
  quadenc_multi_if.slave bus
);
  localparam logic [3:0] FL = 4'(FILT_LEN);
  localparam int         SM = SYNC_STAGES - 1;

  logic [NUM_CH*CNT_W-1:0] cnt_all;
  logic [NUM_CH*CNT_W-1:0] snap_q;
  logic [NUM_CH*CNT_W-1:0] snap_d;
  logic                    sv_q;
  logic                    sv_d;

  // Gray position: 00,10,11,01 map to 0,1,2,3
  function automatic logic [1:0] gpos(input logic [1:0] s);
    return {s[0], s[1] ^ s[0]};
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sa_q;
    logic [SYNC_STAGES-1:0] sb_q;
    logic [1:0]             s;
    logic [1:0]             cand_q, cand_d;
    logic [3:0]             fcnt_q, fcnt_d;
    logic [1:0]             f_q, f_d;
    logic                   fok_q, fok_d;
    logic [1:0]             prev_q, prev_d;
    logic                   primed_q, primed_d;
    logic                   dir_q, dir_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [1:0]             diff;
    logic                   reach;
    logic                   fwd;
    logic                   rev;
    logic                   ill;

    assign s = {sa_q[SM], sb_q[SM]};

    // Plain shift-register synchronisers for A and B
    always_ff @(posedge clk) begin
      if (rst) begin
        sa_q <= '0;
        sb_q <= '0;
      end else begin
        sa_q <= {sa_q[SYNC_STAGES-2:0], bus.quad_a[i]};
        sb_q <= {sb_q[SYNC_STAGES-2:0], bus.quad_b[i]};
      end
    end

    // Filter, priming, transition decode and counter next state
    always_comb begin
      cand_d   = cand_q;
      fcnt_d   = fcnt_q;
      f_d      = f_q;
      fok_d    = fok_q;
      prev_d   = prev_q;
      primed_d = primed_q;
      dir_d    = dir_q;
      count_d  = count_q;
      reach    = 1'b0;
      fwd      = 1'b0;
      rev      = 1'b0;
      ill      = 1'b0;
      diff     = gpos(f_q) - gpos(prev_q);

      if (s == cand_q) begin
        if (fcnt_q != FL) begin
          fcnt_d = fcnt_q + 4'd1;
          reach  = (fcnt_d == FL);
        end
      end else begin
        cand_d = s;
        fcnt_d = 4'd1;
        reach  = (FL == 4'd1);
      end
      if (reach) begin
        f_d   = cand_d;
        fok_d = 1'b1;
      end

      if (fok_q && !primed_q) begin
        prev_d   = f_q;
        primed_d = 1'b1;
      end else if (primed_q && (f_q != prev_q)) begin
        prev_d = f_q;
        unique case (1'b1)
          (diff == 2'd1): fwd = 1'b1;
          (diff == 2'd3): rev = 1'b1;
          default:        ill = 1'b1;
        endcase
      end

      if (fwd) begin
        dir_d = 1'b1;
      end else if (rev) begin
        dir_d = 1'b0;
      end

      if (bus.clear[i]) begin
        count_d = '0;
      end else if (fwd) begin
        count_d = count_q + CNT_W'(1);
      end else if (rev) begin
        count_d = count_q - CNT_W'(1);
      end

      err_d = (err_q & ~bus.err_clr[i]) | ill;
    end

    // Per-channel state registers
    always_ff @(posedge clk) begin
      if (rst) begin
        cand_q   <= '0;
        fcnt_q   <= '0;
        f_q      <= '0;
        fok_q    <= 1'b0;
        prev_q   <= '0;
        primed_q <= 1'b0;
        dir_q    <= 1'b0;
        err_q    <= 1'b0;
        count_q  <= '0;
      end else begin
        cand_q   <= cand_d;
        fcnt_q   <= fcnt_d;
        f_q      <= f_d;
        fok_q    <= fok_d;
        prev_q   <= prev_d;
        primed_q <= primed_d;
        dir_q    <= dir_d;
        err_q    <= err_d;
        count_q  <= count_d;
      end
    end

    assign cnt_all[i*CNT_W +: CNT_W]   = count_q;
    assign bus.count[i*CNT_W +: CNT_W] = count_q;
    assign bus.dir[i]                  = dir_q;
    assign bus.err[i]                  = err_q;
  end

  // Snapshot takes the pre-update counters of the snap cycle
  always_comb begin
    snap_d = snap_q;
    sv_d   = bus.snap;
    if (bus.snap) begin
      snap_d = cnt_all;
    end
  end

  // Snapshot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      sv_q   <= 1'b0;
    end else begin
      snap_q <= snap_d;
      sv_q   <= sv_d;
    end
  end

  assign bus.snap_count = snap_q;
  assign bus.snap_valid = sv_q;
endmodule

// File: tb/tb_quadenc_multi.sv
// Directed bench for quadenc_multi: 4x32 main instance
// plus a 1x8 instance for narrow-counter wrap.
module tb_quadenc_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quadenc_multi_if #(.NUM_CH(4), .CNT_W(32)) bus ();
  quadenc_multi_if #(.NUM_CH(1), .CNT_W(8))  bus8 ();

  quadenc_multi #(
    .NUM_CH(4), .CNT_W(32), .SYNC_STAGES(2), .FILT_LEN(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  quadenc_multi #(
    .NUM_CH(1), .CNT_W(8), .SYNC_STAGES(2), .FILT_LEN(3)
  ) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] ab [4];
  logic [1:0] ab8;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.quad_a[i] = ab[i][1];
      bus.quad_b[i] = ab[i][0];
    end
    bus8.quad_a[0] = ab8[1];
    bus8.quad_b[0] = ab8[0];
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b10:   return 2'b00;
      2'b11:   return 2'b10;
      2'b01:   return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [31:0] cnt(input int i);
    return bus.count[i*32 +: 32];
  endfunction

  function automatic logic [31:0] snp(input int i);
    return bus.snap_count[i*32 +: 32];
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) ab[i] = 2'b00;
    ab[0] = 2'b11;
    ab8 = 2'b00;
    drive();
    bus.clear = '0;
    bus.snap = 1'b0;
    bus.err_clr = '0;
    bus8.clear = '0;
    bus8.snap = 1'b0;
    bus8.err_clr = '0;

    cyc(2);
    chk("rst_count", bus.count, 128'h0);
    chk("rst_snap_count", bus.snap_count, 128'h0);
    chk("rst_dir", bus.dir, 4'h0);
    chk("rst_err", bus.err, 4'h0);
    chk("rst_snap_valid", bus.snap_valid, 1'b0);
    rst = 1'b0;

    cyc(10);
    chk("prime_count0", cnt(0), 32'd0);

    ab[0] = fwd(ab[0]);
    drive();
    cyc(5);
    chk("latency_edge5", cnt(0), 32'd0);
    cyc(1);
    chk("latency_edge6", cnt(0), 32'd1);
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      ab[0] = fwd(ab[0]);
      drive();
      cyc(8);
    end
    chk("fwd4_count0", cnt(0), 32'd4);
    chk("fwd4_dir0", bus.dir[0], 1'b1);
    chk("fwd4_err0", bus.err[0], 1'b0);

    bus.clear[0] = 1'b1;
    cyc(1);
    bus.clear[0] = 1'b0;
    chk("clear_count0", cnt(0), 32'd0);
    ab[0] = rev(ab[0]);
    ab8 = rev(ab8);
    drive();
    cyc(8);
    chk("rev_wrap_count0", cnt(0), 32'hFFFF_FFFF);
    chk("rev_wrap_dir0", bus.dir[0], 1'b0);
    chk("w8_rev_wrap", bus8.count, 8'hFF);
    ab8 = fwd(ab8);
    drive();
    cyc(8);
    chk("w8_fwd_wrap", bus8.count, 8'h00);

    ab[1] = 2'b10;
    drive();
    cyc(2);
    ab[1] = 2'b00;
    drive();
    cyc(10);
    chk("glitch2_count1", cnt(1), 32'd0);
    ab[1] = 2'b10;
    drive();
    cyc(3);
    ab[1] = 2'b00;
    drive();
    cyc(3);
    chk("glitch3_up", cnt(1), 32'd1);
    cyc(6);
    chk("glitch3_down", cnt(1), 32'd0);
    chk("glitch3_dir1", bus.dir[1], 1'b0);

    ab[2] = 2'b11;
    drive();
    cyc(8);
    chk("ill_err2", bus.err[2], 1'b1);
    chk("ill_count2", cnt(2), 32'd0);
    ab[2] = 2'b00;
    drive();
    cyc(5);
    bus.err_clr[2] = 1'b1;
    cyc(1);
    bus.err_clr[2] = 1'b0;
    chk("ill_set_beats_clr", bus.err[2], 1'b1);
    cyc(3);
    bus.err_clr[2] = 1'b1;
    cyc(1);
    bus.err_clr[2] = 1'b0;
    chk("ill_clr_alone", bus.err[2], 1'b0);
    chk("ill_count2_after", cnt(2), 32'd0);

    bus.clear = 4'hF;
    cyc(1);
    bus.clear = 4'h0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (r < 5 + i) ab[i] = fwd(ab[i]);
      end
      drive();
      cyc(8);
    end
    chk("pre_snap_counts", bus.count,
        {32'd8, 32'd7, 32'd6, 32'd5});

    for (int i = 0; i < 4; i++) ab[i] = fwd(ab[i]);
    drive();
    cyc(5);
    bus.snap = 1'b1;
    cyc(1);
    bus.snap = 1'b0;
    chk("snap_count_pre", bus.snap_count,
        {32'd8, 32'd7, 32'd6, 32'd5});
    chk("snap_live_post", bus.count,
        {32'd9, 32'd8, 32'd7, 32'd6});
    chk("snap_valid_hi", bus.snap_valid, 1'b1);
    cyc(1);
    chk("snap_valid_lo", bus.snap_valid, 1'b0);

    bus.snap = 1'b1;
    cyc(1);
    chk("b2b_valid1", bus.snap_valid, 1'b1);
    cyc(1);
    bus.snap = 1'b0;
    chk("b2b_valid2", bus.snap_valid, 1'b1);
    chk("b2b_snap0", snp(0), 32'd6);
    cyc(1);
    chk("b2b_valid_lo", bus.snap_valid, 1'b0);

    ab[3] = fwd(ab[3]);
    drive();
    cyc(5);
    bus.clear[3] = 1'b1;
    cyc(1);
    bus.clear[3] = 1'b0;
    chk("clr_vs_step", cnt(3), 32'd0);
    cyc(3);
    chk("clr_step_gone", cnt(3), 32'd0);

    ab[1] = fwd(fwd(ab[1]));
    drive();
    cyc(8);
    chk("pre_rst_err1", bus.err[1], 1'b1);
    for (int i = 0; i < 4; i++) ab[i] = fwd(ab[i]);
    drive();
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("midrst_count", bus.count, 128'h0);
    chk("midrst_snap", bus.snap_count, 128'h0);
    chk("midrst_dir", bus.dir, 4'h0);
    chk("midrst_err", bus.err, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ab[i] = 2'b10;
    ab8 = 2'b10;
    drive();
    cyc(20);
    chk("reprime_count", bus.count, 128'h0);
    chk("reprime_w8", bus8.count, 8'h00);
    for (int i = 0; i < 4; i++) ab[i] = fwd(ab[i]);
    ab8 = fwd(ab8);
    drive();
    cyc(8);
    chk("reprime_step",
        bus.count, {32'd1, 32'd1, 32'd1, 32'd1});
    chk("reprime_dir", bus.dir, 4'hF);
    chk("reprime_w8_step", bus8.count, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
